// File: rtl/adis_burst_sequencer_pkg.sv
// Shared FSM type, IMU register map and SPI frame helper for the ADIS burst sequencer.
package adis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    STALL   = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  localparam logic [6:0] X_GYRO_OUT = 7'h04;
  localparam logic [6:0] Y_GYRO_OUT = 7'h06;
  localparam logic [6:0] Z_GYRO_OUT = 7'h08;
  localparam logic [6:0] X_ACCL_OUT = 7'h0A;
  localparam logic [6:0] Y_ACCL_OUT = 7'h0C;
  localparam logic [6:0] Z_ACCL_OUT = 7'h0E;

  localparam int NUM_ADDRS = 6;

  // Entry 0 is the rightmost element: gyro X first, accel Z last.
  localparam logic [NUM_ADDRS-1:0][6:0] ADDR_TABLE = {
    Z_ACCL_OUT, Y_ACCL_OUT, X_ACCL_OUT, Z_GYRO_OUT, Y_GYRO_OUT, X_GYRO_OUT
  };

  localparam logic READ_BIT = 1'b0;

  function automatic logic [15:0] read_frame(input logic [6:0] addr);
    return {READ_BIT, addr, 8'h00};
  endfunction

endpackage

// File: rtl/adis_burst_sequencer_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, clearing to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1'b1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adis_burst_sequencer.sv
// Issues the pipelined ADIS register-read burst per trigger, enforces the
// inter-frame stall and publishes one gyro/accel sample atomically.
module adis_burst_sequencer
  import adis_pkg::*;
#(
  parameter int NUM_WORDS    = 6,
  parameter int STALL_CYCLES = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    data_ready,
  input  logic                    dr_enable,
  output logic                    spi_req,
  output logic [15:0]             spi_word,
  input  logic                    spi_done,
  input  logic [15:0]             spi_rdata,
  output logic                    sample_valid,
  output logic [16*NUM_WORDS-1:0] sample_data,
  output logic                    busy,
  output logic                    overrun
);

  localparam int FW = $clog2(NUM_WORDS + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);

  state_e                     state_q, state_d;
  logic [FW-1:0]              frame_idx_q, frame_idx_d;
  logic [SW-1:0]              stall_cnt_q, stall_cnt_d;
  logic [NUM_WORDS-1:0][15:0] shadow_q, shadow_d;
  logic [NUM_WORDS-1:0][15:0] sample_data_q, sample_data_d;
  logic [15:0]                spi_word_q, spi_word_d;
  logic                       spi_req_q, spi_req_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic                       dr_sync_s;
  logic                       dr_prev_q, dr_prev_d;
  logic                       dr_rise_q, dr_rise_d;
  logic                       trig_s;

  // Frame NUM_WORDS is the dummy that flushes the last pipelined response.
  function automatic logic [15:0] frame_word(input logic [FW-1:0] idx);
    logic [6:0] addr;
    if (idx < FW'(NUM_WORDS)) begin
      addr = ADDR_TABLE[idx];
    end else begin
      addr = ADDR_TABLE[0];
    end
    return read_frame(addr);
  endfunction

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_dr_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (data_ready),
    .q    (dr_sync_s)
  );

  always_comb begin
    dr_prev_d = dr_sync_s;
    dr_rise_d = dr_sync_s & ~dr_prev_q;
    trig_s    = start | (dr_enable & dr_rise_q);
  end

  always_comb begin
    state_d        = state_q;
    frame_idx_d    = frame_idx_q;
    stall_cnt_d    = stall_cnt_q;
    shadow_d       = shadow_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          frame_idx_d = '0;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (spi_done) begin
          // The first response belongs to whatever was read before this burst.
          if (frame_idx_q != '0) begin
            shadow_d[frame_idx_q - FW'(1)] = spi_rdata;
          end else begin
            shadow_d = shadow_q;
          end
          stall_cnt_d = '0;
          state_d     = STALL;
        end else begin
          state_d = REQ;
        end
      end
      STALL: begin
        if (stall_cnt_q == SW'(STALL_CYCLES - 1)) begin
          if (frame_idx_q == FW'(NUM_WORDS)) begin
            state_d        = PUBLISH;
            sample_data_d  = shadow_q;
            sample_valid_d = 1'b1;
          end else begin
            frame_idx_d = frame_idx_q + FW'(1);
            state_d     = REQ;
          end
        end else begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    spi_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    overrun_d = trig_s && (state_q != IDLE);
    if (spi_req_d && !spi_req_q) begin
      spi_word_d = frame_word(frame_idx_d);
    end else begin
      spi_word_d = spi_word_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_idx_q    <= '0;
      stall_cnt_q    <= '0;
      shadow_q       <= '0;
      sample_data_q  <= '0;
      spi_word_q     <= 16'h0000;
      spi_req_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      dr_prev_q      <= 1'b0;
      dr_rise_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_idx_q    <= frame_idx_d;
      stall_cnt_q    <= stall_cnt_d;
      shadow_q       <= shadow_d;
      sample_data_q  <= sample_data_d;
      spi_word_q     <= spi_word_d;
      spi_req_q      <= spi_req_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      dr_prev_q      <= dr_prev_d;
      dr_rise_q      <= dr_rise_d;
    end
  end

  assign spi_req      = spi_req_q;
  assign spi_word     = spi_word_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
